// File: rtl/ezpipe_pkg.sv
// ezpipe_pkg: shared opcodes, funct3 codes, LSU states and error codes
package ezpipe_pkg;
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  localparam logic [2:0] FUNCT3_SD  = 3'b011;
  typedef enum logic [1:0] {LSU_IDLE, LSU_ACCESS, LSU_RESP} lsu_state_t;
  localparam logic [1:0] LSU_ERR_OK       = 2'd0;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'd1;
  localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'd3;
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3, input logic xlen64);
    return is_store ? (f3 inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW} || (xlen64 && f3 == FUNCT3_SD))
                    : (f3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU} ||
                       (xlen64 && f3 inside {FUNCT3_LD, FUNCT3_LWU}));
  endfunction
endpackage

// File: rtl/ezpipe_lsu_align.sv
// ezpipe_lsu_align: byte-lane steering for stores, lane extraction and extension for loads
module ezpipe_lsu_align import ezpipe_pkg::*; #(
  parameter int XLEN = 32,
  localparam int BE_W = XLEN / 8,
  localparam int LANE_W = $clog2(BE_W)
) (
  input  logic [2:0]        funct3,
  input  logic [LANE_W-1:0] lane,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [BE_W-1:0]   be,
  output logic [XLEN-1:0]   wdata_lane,
  output logic [XLEN-1:0]   rdata_ext
);
  logic [XLEN-1:0] sh;
  logic            sx;
  // size mask shifted to the lane, store data moved up, load data moved down and extended
  always_comb begin
    be = (funct3[1:0] == 2'd0 ? BE_W'(8'h01) : funct3[1:0] == 2'd1 ? BE_W'(8'h03) :
          funct3[1:0] == 2'd2 ? BE_W'(8'h0f) : BE_W'(8'hff)) << lane;
    wdata_lane = wdata << {lane, 3'b000};
    sh = rdata >> {lane, 3'b000};
    sx = ~funct3[2];
    rdata_ext = funct3[1:0] == 2'd0 ? XLEN'({{56{sx & sh[7]}}, sh[7:0]}) :
                funct3[1:0] == 2'd1 ? XLEN'({{48{sx & sh[15]}}, sh[15:0]}) :
                funct3[1:0] == 2'd2 ? XLEN'({{32{sx & sh[31]}}, sh[31:0]}) : sh;
  end
endmodule

// File: rtl/ezpipe_lsu.sv
// ezpipe_lsu: single-outstanding load/store unit between EXECUTE and WRITE
module ezpipe_lsu import ezpipe_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_store,
  input  logic [2:0]          req_funct3,
  input  logic [XLEN-1:0]     req_base,
  input  logic [11:0]         req_offset,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  input  logic                flush,
  output logic [ADDR_W-1:0]   dbus_addr,
  output logic [XLEN-1:0]     dbus_data_wr,
  output logic [XLEN/8-1:0]   dbus_be,
  output logic                dbus_rd,
  output logic                dbus_wr,
  input  logic [XLEN-1:0]     dbus_data_rd,
  input  logic                dbus_data_ready,
  output logic                resp_valid,
  output logic [4:0]          resp_rd,
  output logic [XLEN-1:0]     resp_data,
  output logic [1:0]          resp_err,
  output logic                busy
);
  localparam int BE_W = XLEN / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ea, addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, data_q, data_d, al_wdata, al_rdata;
  logic [BE_W-1:0]   be_q, be_d, al_be;
  logic              rd_q, rd_d, wr_q, wr_d, flushed_q, flushed_d;
  logic [2:0]        f3_q, f3_d, al_f3, amask;
  logic [LANE_W-1:0] lane_q, lane_d, al_lane;
  logic [4:0]        dest_q, dest_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              illegal, bad, idle, tmo;
  // effective address, request checks and aligner input selection
  always_comb begin
    ea = ADDR_W'(req_base) + {{(ADDR_W-12){req_offset[11]}}, req_offset};
    amask = req_funct3[1:0] == 2'd0 ? 3'b000 : req_funct3[1:0] == 2'd1 ? 3'b001 :
            req_funct3[1:0] == 2'd2 ? 3'b011 : 3'b111;
    illegal = !funct3_legal(req_is_store, req_funct3, XLEN == 64);
    bad = illegal || |(ea[2:0] & amask);
    idle = state_q == LSU_IDLE;
    al_f3 = idle ? req_funct3 : f3_q;
    al_lane = idle ? ea[LANE_W-1:0] : lane_q;
    tmo = TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1);
  end
  ezpipe_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (al_f3),
    .lane       (al_lane),
    .wdata      (req_wdata),
    .rdata      (dbus_data_rd),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata)
  );
  // next state: accept in IDLE, wait for ready or timeout in ACCESS, one response cycle
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    rd_d = rd_q;
    wr_d = wr_q;
    f3_d = f3_q;
    lane_d = lane_q;
    dest_d = dest_q;
    data_d = data_q;
    err_d = err_q;
    cnt_d = cnt_q;
    flushed_d = flushed_q;
    case (state_q)
      LSU_IDLE: if (req_valid && !flush) begin
        f3_d = req_funct3;
        lane_d = ea[LANE_W-1:0];
        data_d = '0;
        cnt_d = '0;
        flushed_d = 1'b0;
        err_d = illegal ? LSU_ERR_ILLEGAL : bad ? LSU_ERR_MISALIGN : LSU_ERR_OK;
        dest_d = bad || req_is_store ? 5'd0 : req_rd;
        state_d = bad ? LSU_RESP : LSU_ACCESS;
        rd_d = !bad && !req_is_store;
        wr_d = !bad && req_is_store;
        addr_d = {ea[ADDR_W-1:LANE_W], LANE_W'(0)};
        be_d = bad ? '0 : al_be;
        wdata_d = !bad && req_is_store ? al_wdata : '0;
      end
      LSU_ACCESS: begin
        flushed_d = flushed_q | flush;
        if (dbus_data_ready || tmo) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          data_d = dbus_data_ready && rd_q ? al_rdata : '0;
          err_d = dbus_data_ready ? LSU_ERR_OK : LSU_ERR_TIMEOUT;
          dest_d = dbus_data_ready ? dest_q : 5'd0;
          state_d = flushed_q || flush ? LSU_IDLE : LSU_RESP;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = LSU_IDLE;
    endcase
  end
  // state and bus/response registers; reset drops strobes immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LSU_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      f3_q <= '0;
      lane_q <= '0;
      dest_q <= '0;
      data_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      f3_q <= f3_d;
      lane_q <= lane_d;
      dest_q <= dest_d;
      data_q <= data_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      flushed_q <= flushed_d;
    end
  end
  assign req_ready = idle;
  assign busy = !idle;
  assign dbus_addr = addr_q;
  assign dbus_data_wr = wdata_q;
  assign dbus_be = be_q;
  assign dbus_rd = rd_q;
  assign dbus_wr = wr_q;
  assign resp_valid = state_q == LSU_RESP && !flush;
  assign resp_rd = resp_valid ? dest_q : '0;
  assign resp_data = resp_valid ? data_q : '0;
  assign resp_err = resp_valid ? err_q : '0;
endmodule

// File: tb/tb_ezpipe_lsu.sv
// tb_ezpipe_lsu: directed checks of ezpipe_lsu at XLEN 32 (TIMEOUT 4) and XLEN 64
module tb_ezpipe_lsu;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic        a_req_valid, a_req_ready, a_req_is_store, a_flush;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_base, a_req_wdata, a_dbus_addr, a_dbus_data_wr, a_dbus_data_rd, a_resp_data;
  logic [11:0] a_req_offset;
  logic [4:0]  a_req_rd, a_resp_rd;
  logic [3:0]  a_dbus_be;
  logic        a_dbus_rd, a_dbus_wr, a_dbus_data_ready, a_resp_valid, a_busy;
  logic [1:0]  a_resp_err;
  logic        b_req_valid, b_req_ready, b_req_is_store, b_flush;
  logic [2:0]  b_req_funct3;
  logic [63:0] b_req_base, b_req_wdata, b_dbus_addr, b_dbus_data_wr, b_dbus_data_rd, b_resp_data;
  logic [11:0] b_req_offset;
  logic [4:0]  b_req_rd, b_resp_rd;
  logic [7:0]  b_dbus_be;
  logic        b_dbus_rd, b_dbus_wr, b_dbus_data_ready, b_resp_valid, b_busy;
  logic [1:0]  b_resp_err;
  int checks = 0;
  int errors = 0;
  int n;
  ezpipe_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_is_store(a_req_is_store), .req_funct3(a_req_funct3), .req_base(a_req_base),
    .req_offset(a_req_offset), .req_wdata(a_req_wdata), .req_rd(a_req_rd), .flush(a_flush),
    .dbus_addr(a_dbus_addr), .dbus_data_wr(a_dbus_data_wr), .dbus_be(a_dbus_be),
    .dbus_rd(a_dbus_rd), .dbus_wr(a_dbus_wr), .dbus_data_rd(a_dbus_data_rd),
    .dbus_data_ready(a_dbus_data_ready), .resp_valid(a_resp_valid), .resp_rd(a_resp_rd),
    .resp_data(a_resp_data), .resp_err(a_resp_err), .busy(a_busy)
  );
  ezpipe_lsu #(.XLEN(64), .ADDR_W(64)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_is_store(b_req_is_store), .req_funct3(b_req_funct3), .req_base(b_req_base),
    .req_offset(b_req_offset), .req_wdata(b_req_wdata), .req_rd(b_req_rd), .flush(b_flush),
    .dbus_addr(b_dbus_addr), .dbus_data_wr(b_dbus_data_wr), .dbus_be(b_dbus_be),
    .dbus_rd(b_dbus_rd), .dbus_wr(b_dbus_wr), .dbus_data_rd(b_dbus_data_rd),
    .dbus_data_ready(b_dbus_data_ready), .resp_valid(b_resp_valid), .resp_rd(b_resp_rd),
    .resp_data(b_resp_data), .resp_err(b_resp_err), .busy(b_busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue_a(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [11:0] off, input logic [31:0] wd, input logic [4:0] rd);
    a_req_valid = 1'b1;
    a_req_is_store = st;
    a_req_funct3 = f3;
    a_req_base = base;
    a_req_offset = off;
    a_req_wdata = wd;
    a_req_rd = rd;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    {a_req_valid, a_req_is_store, a_flush, a_dbus_data_ready} = '0;
    {a_req_funct3, a_req_base, a_req_wdata, a_req_offset, a_req_rd, a_dbus_data_rd} = '0;
    {b_req_valid, b_req_is_store, b_flush, b_dbus_data_ready} = '0;
    {b_req_funct3, b_req_base, b_req_wdata, b_req_offset, b_req_rd, b_dbus_data_rd} = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", a_req_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_strobes", {a_dbus_rd, a_dbus_wr}, 0);
    chk("rst_resp", a_resp_valid, 0);
    chk("rst_be", a_dbus_be, 0);
    reset = 1'b0;
    @(negedge clk);
    issue_a(0, 3'b010, 32'h1000, 12'hffc, 32'h0, 5'd5);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("lw_rd", a_dbus_rd, 1);
    chk("lw_addr", a_dbus_addr, 32'h0ffc);
    chk("lw_be", a_dbus_be, 4'hf);
    chk("lw_ready_low", a_req_ready, 0);
    chk("lw_no_resp_yet", a_resp_valid, 0);
    a_dbus_data_ready = 1'b1;
    a_dbus_data_rd = 32'hdeadbeef;
    @(negedge clk);
    a_dbus_data_ready = 1'b0;
    chk("lw_valid", a_resp_valid, 1);
    chk("lw_data", a_resp_data, 32'hdeadbeef);
    chk("lw_rd_dest", a_resp_rd, 5);
    chk("lw_err", a_resp_err, 0);
    chk("lw_strobe_drop", a_dbus_rd, 0);
    @(negedge clk);
    chk("lw_pulse", a_resp_valid, 0);
    chk("lw_idle", a_req_ready, 1);
    issue_a(0, 3'b000, 32'h1003, 12'h0, 32'h0, 5'd6);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("lb_be", a_dbus_be, 4'b1000);
    chk("lb_addr", a_dbus_addr, 32'h1000);
    a_dbus_data_ready = 1'b1;
    a_dbus_data_rd = 32'h80123456;
    @(negedge clk);
    a_dbus_data_ready = 1'b0;
    chk("lb_valid", a_resp_valid, 1);
    chk("lb_data", a_resp_data, 32'hffffff80);
    @(negedge clk);
    issue_a(0, 3'b100, 32'h1003, 12'h0, 32'h0, 5'd6);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_dbus_data_ready = 1'b1;
    @(negedge clk);
    a_dbus_data_ready = 1'b0;
    chk("lbu_data", a_resp_data, 32'h00000080);
    @(negedge clk);
    issue_a(0, 3'b001, 32'h1001, 12'h0, 32'h0, 5'd7);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("lh_valid", a_resp_valid, 1);
    chk("lh_err", a_resp_err, 1);
    chk("lh_no_strobe", {a_dbus_rd, a_dbus_wr}, 0);
    chk("lh_rd_dest", a_resp_rd, 0);
    @(negedge clk);
    issue_a(1, 3'b001, 32'h2000, 12'd2, 32'h1234abcd, 5'd7);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("sh_wr", a_dbus_wr, 1);
    chk("sh_rd", a_dbus_rd, 0);
    chk("sh_addr", a_dbus_addr, 32'h2000);
    chk("sh_be", a_dbus_be, 4'b1100);
    chk("sh_wdata", a_dbus_data_wr[31:16], 16'habcd);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sh_hold_wr", a_dbus_wr, 1);
      chk("sh_hold_addr", a_dbus_addr, 32'h2000);
      chk("sh_hold_be", a_dbus_be, 4'b1100);
      chk("sh_hold_noresp", a_resp_valid, 0);
    end
    a_dbus_data_ready = 1'b1;
    @(negedge clk);
    a_dbus_data_ready = 1'b0;
    chk("sh_valid", a_resp_valid, 1);
    chk("sh_rd_dest", a_resp_rd, 0);
    chk("sh_err", a_resp_err, 0);
    chk("sh_wr_drop", a_dbus_wr, 0);
    @(negedge clk);
    issue_a(0, 3'b010, 32'h3000, 12'h0, 32'h0, 5'd8);
    @(negedge clk);
    a_req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && !a_resp_valid; i++) begin
      if (a_dbus_rd) n++;
      @(negedge clk);
    end
    chk("tmo_strobe_cycles", n, 4);
    chk("tmo_valid", a_resp_valid, 1);
    chk("tmo_err", a_resp_err, 3);
    chk("tmo_rd_dest", a_resp_rd, 0);
    chk("tmo_strobe_drop", a_dbus_rd, 0);
    @(negedge clk);
    issue_a(0, 3'b011, 32'h1001, 12'h0, 32'h0, 5'd9);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("ld32_valid", a_resp_valid, 1);
    chk("ld32_err", a_resp_err, 2);
    chk("ld32_no_strobe", {a_dbus_rd, a_dbus_wr}, 0);
    @(negedge clk);
    issue_a(1, 3'b100, 32'h1000, 12'h0, 32'h0, 5'd9);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("st100_err", a_resp_err, 2);
    @(negedge clk);
    issue_a(0, 3'b010, 32'h4000, 12'h0, 32'h0, 5'd3);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("fla_rd", a_dbus_rd, 1);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    chk("fla_no_abort", a_dbus_rd, 1);
    chk("fla_busy", a_busy, 1);
    a_dbus_data_ready = 1'b1;
    a_dbus_data_rd = 32'h11111111;
    @(negedge clk);
    a_dbus_data_ready = 1'b0;
    chk("fla_no_resp", a_resp_valid, 0);
    chk("fla_drop", a_dbus_rd, 0);
    chk("fla_idle", a_req_ready, 1);
    issue_a(0, 3'b010, 32'h5000, 12'h0, 32'h0, 5'd3);
    a_flush = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0;
    a_flush = 1'b0;
    chk("fli_ready", a_req_ready, 1);
    chk("fli_no_strobe", a_dbus_rd, 0);
    chk("fli_busy", a_busy, 0);
    @(negedge clk);
    chk("fli_no_resp", a_resp_valid, 0);
    issue_a(0, 3'b010, 32'h6000, 12'h0, 32'h0, 5'd4);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_dbus_data_ready = 1'b1;
    a_dbus_data_rd = 32'h12345678;
    @(negedge clk);
    a_dbus_data_ready = 1'b0;
    chk("flr_pre", a_resp_valid, 1);
    a_flush = 1'b1;
    #1;
    chk("flr_suppressed", a_resp_valid, 0);
    a_flush = 1'b0;
    @(negedge clk);
    chk("flr_idle", a_req_ready, 1);
    issue_a(0, 3'b010, 32'h7000, 12'h0, 32'h0, 5'd2);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("rma_rd", a_dbus_rd, 1);
    #1 reset = 1'b1;
    #1;
    chk("rma_drop", a_dbus_rd, 0);
    chk("rma_ready", a_req_ready, 1);
    chk("rma_busy", a_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rma_no_resp", a_resp_valid, 0);
    b_req_valid = 1'b1;
    b_req_funct3 = 3'b110;
    b_req_base = 64'h1000;
    b_req_offset = 12'd4;
    b_req_rd = 5'd9;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("lwu64_be", b_dbus_be, 8'hf0);
    chk("lwu64_addr", b_dbus_addr, 64'h1000);
    chk("lwu64_rd", b_dbus_rd, 1);
    b_dbus_data_ready = 1'b1;
    b_dbus_data_rd = 64'h8000_0001_1234_5678;
    @(negedge clk);
    b_dbus_data_ready = 1'b0;
    chk("lwu64_valid", b_resp_valid, 1);
    chk("lwu64_data", b_resp_data, 64'h0000_0000_8000_0001);
    chk("lwu64_rd_dest", b_resp_rd, 9);
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_funct3 = 3'b010;
    @(negedge clk);
    b_req_valid = 1'b0;
    b_dbus_data_ready = 1'b1;
    @(negedge clk);
    b_dbus_data_ready = 1'b0;
    chk("lw64_data", b_resp_data, 64'hffff_ffff_8000_0001);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
